// File: rtl/nios2_camera_sdram_lcd_cpu_oci_dtrace_pkg.sv
// ---------------------------------------------------------------------------
// nios2_camera_sdram_lcd_cpu_oci_dtrace_pkg
// Shared OCI data/control-trace definitions:
//   - trace RAM geometry and fragment packing constants
//   - trace word field offsets: {count @33:30, data @29:0}
//   - arbiter FSM state encodings
//   - pack_word(): assembles a trace RAM word from count and buffer
// ---------------------------------------------------------------------------
package nios2_camera_sdram_lcd_cpu_oci_dtrace_pkg;

  localparam int ADDR_W   = 7;                 // 128-word trace RAM
  localparam int FRAG_W   = 2;                 // trace fragment width
  localparam int NFRAG    = 15;                // fragments per trace word
  localparam int BUF_W    = NFRAG * FRAG_W;    // 30-bit packing buffer
  localparam int CNT_W    = 4;                 // fragment count field width
  localparam int WORD_W   = CNT_W + BUF_W;     // 34-bit RAM word

  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = BUF_W - 1;         // 29
  localparam int CNT_LSB  = BUF_W;             // 30
  localparam int CNT_MSB  = WORD_W - 1;        // 33

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NFRAG);

  // Arbiter for the shared single-port trace RAM.
  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } arb_state_t;

  function automatic logic [WORD_W-1:0] pack_word(input logic [CNT_W-1:0] cnt,
                                                  input logic [BUF_W-1:0] data);
    logic [WORD_W-1:0] w;
    w = '0;
    w[CNT_MSB:CNT_LSB]   = cnt;
    w[DATA_MSB:DATA_LSB] = data;
    return w;
  endfunction

endpackage

// File: rtl/nios2_camera_sdram_lcd_cpu_oci_dtrace_packer.sv
// ---------------------------------------------------------------------------
// nios2_camera_sdram_lcd_cpu_oci_dtrace_packer
// Packs 2-bit trace fragments into a 30-bit buffer and emits a completed
// trace word either when 15 fragments are collected or when a flush is
// requested (flush_req pulse or trc_on falling edge) with a non-empty buffer.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   trc_on                trace enable (falling edge forces a flush)
//   frag_valid, frag      fragment strobe and data (ignored while trc_on=0)
//   flush_req             single-cycle flush request
//   push, word            combinational: completed word offered this cycle
//   dct_buffer, dct_count current packing buffer and its fragment count
// ---------------------------------------------------------------------------
module nios2_camera_sdram_lcd_cpu_oci_dtrace_packer
  import nios2_camera_sdram_lcd_cpu_oci_dtrace_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trc_on,
  input  logic              frag_valid,
  input  logic [FRAG_W-1:0] frag,
  input  logic              flush_req,
  output logic              push,
  output logic [WORD_W-1:0] word,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count
);

  logic             trc_on_q;
  logic             frag_take;
  logic             trc_fall;
  logic             full;
  logic             flush_any;
  logic [BUF_W-1:0] ins_buf;
  logic [CNT_W-1:0] ins_cnt;

  // A fragment arriving in the same cycle as a flush is inserted first, so
  // every decision below works on the post-insert buffer and count.
  always_comb begin
    frag_take = frag_valid & trc_on;
    trc_fall  = trc_on_q & ~trc_on;
    ins_buf   = frag_take ? {dct_buffer[BUF_W-FRAG_W-1:0], frag} : dct_buffer;
    ins_cnt   = dct_count + {{(CNT_W-1){1'b0}}, frag_take};
    full      = (ins_cnt == CNT_FULL);
    flush_any = (flush_req | trc_fall) & (ins_cnt != '0);
    push      = full | flush_any;
    // Newest fragment sits at the LSB, so a partial word is right-aligned.
    word      = pack_word(ins_cnt, ins_buf);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      trc_on_q   <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
    end else begin
      trc_on_q <= trc_on;
      if (push) begin
        dct_buffer <= '0;
        dct_count  <= '0;
      end else begin
        dct_buffer <= ins_buf;
        dct_count  <= ins_cnt;
      end
    end
  end

endmodule

// File: rtl/nios2_camera_sdram_lcd_cpu_oci_dtrace_ctrl.sv
// ---------------------------------------------------------------------------
// nios2_camera_sdram_lcd_cpu_oci_dtrace_ctrl
// Data/control-trace controller of the OCI debug block. Completed trace
// words from the packer enter a 2-entry pending FIFO and are written to a
// single-port trace RAM. The RAM port is shared with debugger readback;
// trace writes take priority, reads are served when no word is pending.
//
// Handshakes:
//   dbg_rd_req is held high with a stable dbg_rd_addr until dbg_rd_ack; the
//   ack is a 1-cycle pulse and dbg_rd_data is valid only in that cycle.
//   Unblocked read: request seen in cycle N -> ack in cycle N+2.
//   ram_rdata returns the word addressed by ram_addr one cycle after the RAM
//   samples it (RAM has 1-cycle registered read latency).
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   trc_on, frag_valid, frag trace enable and fragment input
//   flush_req                flush the partial word
//   dbg_rd_req/addr/ack/data debugger readback
//   ram_we/addr/wdata/rdata  trace RAM port
//   wr_ptr                   next RAM write address
//   wrapped, overflow        sticky status
//   dct_buffer, dct_count    packing state for the OCI monitor
//   arb_hold                 debug stall: while high the arbiter neither
//                            writes nor starts reads; tie low in normal use
//   arb_state                current arbiter state (debug visibility)
// ---------------------------------------------------------------------------
module nios2_camera_sdram_lcd_cpu_oci_dtrace_ctrl
  import nios2_camera_sdram_lcd_cpu_oci_dtrace_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trc_on,
  input  logic              frag_valid,
  input  logic [FRAG_W-1:0] frag,
  input  logic              flush_req,
  input  logic              dbg_rd_req,
  input  logic [ADDR_W-1:0] dbg_rd_addr,
  output logic              dbg_rd_ack,
  output logic [WORD_W-1:0] dbg_rd_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic              overflow,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  input  logic              arb_hold,
  output logic              arb_state
);

  arb_state_t        state;

  logic              pk_push;
  logic [WORD_W-1:0] pk_word;

  logic [WORD_W-1:0] fifo_mem [2];
  logic              fifo_rd_idx;
  logic              fifo_wr_idx;
  logic [1:0]        fifo_cnt;

  logic              fifo_empty;
  logic              fifo_full;
  logic              can_write;
  logic              pop;
  logic              bypass;
  logic              fifo_wr;
  logic              drop;
  logic              rd_start;
  logic [WORD_W-1:0] head_word;

  nios2_camera_sdram_lcd_cpu_oci_dtrace_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .trc_on     (trc_on),
    .frag_valid (frag_valid),
    .frag       (frag),
    .flush_req  (flush_req),
    .push       (pk_push),
    .word       (pk_word),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count)
  );

  // A word completing while the FIFO is empty and the arbiter is free is
  // written straight through, so it blocks a concurrent read by one cycle
  // only. In RD_WAIT the word lands in the FIFO and waits.
  always_comb begin
    fifo_empty = (fifo_cnt == 2'd0);
    fifo_full  = (fifo_cnt == 2'd2);
    can_write  = (state == ARB_IDLE) & ~arb_hold;
    pop        = can_write & ~fifo_empty;
    bypass     = can_write & fifo_empty & pk_push;
    head_word  = fifo_empty ? pk_word : fifo_mem[fifo_rd_idx];
    fifo_wr    = pk_push & ~bypass & (~fifo_full | pop);
    drop       = pk_push & ~bypass & fifo_full & ~pop;
    // dbg_rd_ack high means the requester drops its request next cycle;
    // do not start a second read on the still-asserted request.
    rd_start   = can_write & fifo_empty & ~pk_push & dbg_rd_req & ~dbg_rd_ack;
  end

  // Pending FIFO storage: contents need no reset, occupancy does.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[fifo_wr_idx] <= pk_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fifo_rd_idx <= 1'b0;
      fifo_wr_idx <= 1'b0;
      fifo_cnt    <= 2'd0;
      overflow    <= 1'b0;
    end else begin
      if (fifo_wr) begin
        fifo_wr_idx <= ~fifo_wr_idx;
      end
      if (pop) begin
        fifo_rd_idx <= ~fifo_rd_idx;
      end
      case ({fifo_wr, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Arbiter FSM with registered RAM-side and ack outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      wr_ptr     <= '0;
      wrapped    <= 1'b0;
      dbg_rd_ack <= 1'b0;
    end else begin
      ram_we     <= 1'b0;
      ram_addr   <= wr_ptr;
      dbg_rd_ack <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pop | bypass) begin
            ram_we    <= 1'b1;
            ram_addr  <= wr_ptr;
            ram_wdata <= head_word;
            wr_ptr    <= wr_ptr + 1'b1;
            if (wr_ptr == '1) begin
              wrapped <= 1'b1;
            end
          end else if (rd_start) begin
            ram_addr <= dbg_rd_addr;
            state    <= ARB_RD_WAIT;
          end
        end
        ARB_RD_WAIT: begin
          // RAM sampled the read address at this edge; data arrives with
          // the ack in the next cycle.
          dbg_rd_ack <= 1'b1;
          state      <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign dbg_rd_data = dbg_rd_ack ? ram_rdata : '0;
  assign arb_state   = state;

endmodule
